imem_loadable: RTL
==================

Name: imem_loadable

Overview:
- Parametrised, loadable instruction memory for the pipelined RV32 core; successor to the fixed, file-initialised instruction ROM.
- Fetch port: registered 1-cycle read with stall hold, NOP injection and fault flags for misaligned or out-of-range PCs.
- Load port: valid/ready stream that writes a program image into the memory at run time, driven by a small loader FSM.
- Sits between the IF-stage PC register and the IF/ID pipeline register.

Parameters:
- XLEN, 32, instruction/PC width in bits
- DEPTH, 128, number of 32-bit words; must be a power of two ≥ 2
- AW, $clog2(DEPTH), word-address width (derived, not overridden)
- NOP_WORD, 32'h00000013, word injected on faults and bubbles (addi x0,x0,0)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- load_start  in  1  one-cycle request to begin a load burst
- load_base  in  AW  first word address of the burst
- load_len  in  AW+1  number of words in the burst, 0..DEPTH
- load_valid  in  1  load_data valid
- load_data  in  XLEN  word to write
- load_ready  out  1  memory accepts load_data this cycle
- load_busy  out  1  loader not in IDLE
- load_done  out  1  one-cycle pulse when a burst completes
- fetch_en  in  1  fetch request this cycle
- stall  in  1  hold the fetch outputs
- pc_in  in  XLEN  byte address to fetch
- instr_out  out  XLEN  fetched instruction (registered)
- instr_valid  out  1  instr_out is a real fetch result
- fault_misalign  out  1  registered; pc_in[1:0] ≠ 0 on the fetch
- fault_range  out  1  registered; pc_in[XLEN-1:2] ≥ DEPTH on the fetch

Behaviour:
- Reset (rst_n=0 at a clock edge): FSM→IDLE; instr_out=NOP_WORD; instr_valid, fault_*, load_ready, load_busy, load_done all 0.
- Reset does not clear memory contents. Reset mid-load aborts the burst; words already written remain.
- Loader FSM states:
  - IDLE: load_start=1 → if load_len=0 go to DONE, else latch ptr=load_base and cnt=load_len, go to LOAD. load_start is ignored in every other state.
  - LOAD: load_ready=1. On load_valid&&load_ready, write mem[ptr]=load_data, ptr=(ptr+1) mod DEPTH (wraps), cnt=cnt−1. When cnt reaches 0 on the final write, go to DONE.
  - DONE: load_done=1 for exactly one cycle, then go to IDLE.
- load_busy=1 in LOAD and DONE.
- Fetch path:
  - Fetches are served only in IDLE and only on a cycle where load_start=0. When both are asserted in IDLE, load_start wins and the fetch is dropped.
  - stall=1 freezes instr_out, instr_valid and fault_* (highest priority after reset).
  - Otherwise, on each edge:
    - fetch_en=0 or fetch blocked → instr_out=NOP_WORD, instr_valid=0, fault_*=0.
    - Misaligned → instr_out=NOP_WORD, instr_valid=1, fault_misalign=1. Misaligned has priority over range: fault_range=0.
    - Out of range (aligned) → instr_out=NOP_WORD, instr_valid=1, fault_range=1.
    - Normal fetch → instr_out=mem[pc_in[AW+1:2]], instr_valid=1, fault_*=0.
- Latency: result is visible 1 cycle after the fetch_en edge.
- Read-during-load is impossible because fetch is blocked while the loader is active. A fetch of a word written in the previous cycle returns the new data.
- pc_in is treated as unsigned; high PCs are range faults.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles while fetch_en=1 → instr_out=32'h00000013, instr_valid=0, load_busy=0, load_done=0.
- Load then fetch:
  - Stimulus: load_start with base=0, len=3; data 0x00500093, 0x00308113, 0x002081B3 on consecutive cycles.
  - Required: load_done pulses exactly 1 cycle after the 3rd write.
  - Then fetch pc=0,4,8 → each word returned 1 cycle later with instr_valid=1.
- Wrap, backpressure and len=0:
  - base=DEPTH−1, len=2, load_valid toggled 1,0,1 → mem[127] and mem[0] written; only 2 handshakes are counted.
  - len=0 → load_done 1 cycle after load_start, no writes.
- Faults:
  - pc=0x6 → NOP, instr_valid=1, fault_misalign=1.
  - pc=0x200 (word 128) → NOP, fault_range=1.
  - pc=0x202 → fault_misalign=1 only.
- Stall and priority:
  - Fetch pc=4, then stall=1 for 3 cycles while pc changes → outputs hold the pc=4 word.
  - load_start and fetch_en asserted together in IDLE → instr_valid=0 next cycle; load_busy=1.
- Reset mid-load: rst_n=0 after 2 of 5 words → FSM in IDLE, no load_done pulse; the first 2 words are readable afterward.

Source files
------------

// File: rtl/imem_loadable.sv
// Loadable instruction memory: registered fetch port with stall/NOP/fault handling,
// plus a valid/ready load port driven by a three-state loader FSM.
module imem_loadable #(
  parameter int unsigned          XLEN     = 32,
  parameter int unsigned          DEPTH    = 128,
  parameter logic [XLEN-1:0]      NOP_WORD = 32'h0000_0013,
  localparam int unsigned         AW       = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_start,
  input  logic [AW-1:0]   load_base,
  input  logic [AW:0]     load_len,
  input  logic            load_valid,
  input  logic [XLEN-1:0] load_data,
  output logic            load_ready,
  output logic            load_busy,
  output logic            load_done,
  input  logic            fetch_en,
  input  logic            stall,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] instr_out,
  output logic            instr_valid,
  output logic            fault_misalign,
  output logic            fault_range
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            fm_q, fm_d;
  logic            fr_q, fr_d;
  logic            mem_we;
  logic            fetch_go;
  logic            pc_misalign;
  logic            pc_oor;

  logic [XLEN-1:0] mem_q [DEPTH];

  // Loader FSM next state; memory write gated by rst_n so a reset edge never writes.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          if (load_len == '0) begin
            state_d = StDone;
          end else begin
            ptr_d   = load_base;
            cnt_d   = load_len;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (load_valid) begin
          mem_we = rst_n;
          ptr_d  = ptr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == (AW+1)'(1)) state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign load_ready = (state_q == StLoad);
  assign load_busy  = (state_q != StIdle);
  assign load_done  = (state_q == StDone);

  assign fetch_go    = fetch_en && (state_q == StIdle) && !load_start;
  assign pc_misalign = (pc_in[1:0] != 2'b00);
  assign pc_oor      = |pc_in[XLEN-1:AW+2];

  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    fm_d    = fm_q;
    fr_d    = fr_q;
    if (!stall) begin
      instr_d = NOP_WORD;
      valid_d = fetch_go;
      fm_d    = 1'b0;
      fr_d    = 1'b0;
      if (fetch_go) begin
        if (pc_misalign) begin
          fm_d = 1'b1;
        end else if (pc_oor) begin
          fr_d = 1'b1;
        end else begin
          instr_d = mem_q[pc_in[AW+1:2]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fm_q    <= 1'b0;
      fr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fm_q    <= fm_d;
      fr_q    <= fr_d;
    end
  end

  // Contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ptr_q] <= load_data;
  end

  assign instr_out      = instr_q;
  assign instr_valid    = valid_q;
  assign fault_misalign = fm_q;
  assign fault_range    = fr_q;

endmodule
